bottle_ctrl: RTL and testbench

BOTTLE_CTRL -- requirements
Module: bottle_ctrl

---
 rtl/bottle_pkg.sv | 18 +
 rtl/bottle_ctrl_bcd2_counter.sv | 40 ++++
 rtl/bottle_ctrl.sv | 137 +++++++++++++
 tb/tb_bottle_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bottle_pkg.sv
// Shared types and BCD helpers for the bottle filling controller.
package bottle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WORK  = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MIN = 4'd0;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= DIGIT_MAX) ? DIGIT_MIN : d + 4'd1;
  endfunction

endpackage

// File: rtl/bottle_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter, wraps 99 -> 00; inc_hit flags that the
// post-increment value would equal the compare value.
module bcd2_counter
  import bottle_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] cmp_h,
  input  logic [3:0] cmp_l,
  output logic [3:0] ten,
  output logic [3:0] one,
  output logic       inc_hit
);

  logic [3:0] ten_nxt;
  logic [3:0] one_nxt;

  always_comb begin
    one_nxt = bcd_inc(one);
    ten_nxt = (one >= DIGIT_MAX) ? bcd_inc(ten) : ten;
  end

  assign inc_hit = (ten_nxt == cmp_h) && (one_nxt == cmp_l);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ten <= DIGIT_MIN;
      one <= DIGIT_MIN;
    end else if (clr) begin
      ten <= DIGIT_MIN;
      one <= DIGIT_MIN;
    end else if (inc) begin
      ten <= ten_nxt;
      one <= one_nxt;
    end
  end

endmodule

// File: rtl/bottle_ctrl.sv
// Bottle filling controller: mode FSM, target-digit editor and page timer.
// All outputs are registered from the next state, so they follow a key by one cycle.
module bottle_ctrl
  import bottle_pkg::*;
#(
  parameter int         PAGE_TICKS = 100,
  parameter logic [3:0] MAX_INIT_H = 4'd1,
  parameter logic [3:0] MAX_INIT_L = 4'd2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start_key,
  input  logic       stop_key,
  input  logic       set_key,
  input  logic       sel_key,
  input  logic       inc_key,
  input  logic       bottle,
  output logic       EN,
  output logic       SET,
  output logic       EN_work,
  output logic       EN_set,
  output logic       print1,
  output logic [3:0] max2,
  output logic [3:0] max1,
  output logic [3:0] ten,
  output logic [3:0] one,
  output logic       full
);

  localparam int TW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
  localparam logic [TW-1:0] PAGE_LAST = TW'(PAGE_TICKS - 1);

  state_t        state;
  state_t        state_nxt;
  logic          sel_hi;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          inc_hit;
  logic          can_start;
  logic [TW-1:0] page_cnt;

  bcd2_counter u_cnt (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cmp_h   (max2),
    .cmp_l   (max1),
    .ten     (ten),
    .one     (one),
    .inc_hit (inc_hit)
  );

  assign can_start = ({ten, one} < {max2, max1}) && ({max2, max1} != 8'h00);

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (set_key)                     state_nxt = ST_SETUP;
        else if (start_key && can_start) state_nxt = ST_WORK;
      end
      ST_SETUP: begin
        if (set_key) state_nxt = ST_SETUP == state ? ST_IDLE : state;
      end
      ST_WORK: begin
        // A same-cycle bottle is counted before stop, and reaching target beats stop.
        cnt_inc = bottle;
        if (bottle && inc_hit) state_nxt = ST_FULL;
        else if (stop_key)     state_nxt = ST_IDLE;
      end
      ST_FULL: begin
        if (start_key) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_WORK;
        end else if (stop_key) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      EN      <= 1'b0;
      SET     <= 1'b0;
      EN_work <= 1'b0;
      EN_set  <= 1'b0;
      full    <= 1'b0;
    end else begin
      state   <= state_nxt;
      EN      <= (state_nxt == ST_WORK) || (state_nxt == ST_FULL);
      SET     <= (state_nxt == ST_SETUP);
      EN_work <= (state_nxt == ST_WORK);
      EN_set  <= (state_nxt == ST_SETUP);
      full    <= (state_nxt == ST_FULL);
    end
  end

  // Simultaneous sel+inc bumps the digit selected before the toggle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      max2   <= MAX_INIT_H;
      max1   <= MAX_INIT_L;
      sel_hi <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (state_nxt == ST_SETUP) sel_hi <= 1'b0;
    end else if (state == ST_SETUP) begin
      if (inc_key) begin
        if (sel_hi) max2 <= bcd_inc(max2);
        else        max1 <= bcd_inc(max1);
      end
      if (sel_key) sel_hi <= ~sel_hi;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      page_cnt <= '0;
      print1   <= 1'b0;
    end else if ((state != ST_WORK) || (state_nxt != ST_WORK)) begin
      page_cnt <= '0;
      print1   <= 1'b0;
    end else if (page_cnt == PAGE_LAST) begin
      page_cnt <= '0;
      print1   <= ~print1;
    end else begin
      page_cnt <= page_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_bottle_ctrl.sv
// Directed vector bench for bottle_ctrl with a short page period.
module tb_bottle_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start_key = 1'b0, stop_key = 1'b0, set_key = 1'b0;
  logic       sel_key = 1'b0, inc_key = 1'b0, bottle = 1'b0;
  logic       EN, SET, EN_work, EN_set, print1, full;
  logic [3:0] max2, max1, ten, one;

  bottle_ctrl #(.PAGE_TICKS(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .start_key(start_key), .stop_key(stop_key), .set_key(set_key),
    .sel_key(sel_key), .inc_key(inc_key), .bottle(bottle),
    .EN(EN), .SET(SET), .EN_work(EN_work), .EN_set(EN_set), .print1(print1),
    .max2(max2), .max1(max1), .ten(ten), .one(one), .full(full)
  );

  always #5 CLK = ~CLK;

  localparam logic [5:0] K_NONE  = 6'b000000;
  localparam logic [5:0] K_START = 6'b100000;
  localparam logic [5:0] K_STOP  = 6'b010000;
  localparam logic [5:0] K_SET   = 6'b001000;
  localparam logic [5:0] K_SEL   = 6'b000100;
  localparam logic [5:0] K_INC   = 6'b000010;
  localparam logic [5:0] K_BOT   = 6'b000001;

  // Flag order: EN, SET, EN_work, EN_set, full
  localparam logic [4:0] F_IDLE  = 5'b00000;
  localparam logic [4:0] F_SETUP = 5'b01010;
  localparam logic [4:0] F_WORK  = 5'b10100;
  localparam logic [4:0] F_FULL  = 5'b10001;

  typedef struct {
    logic [5:0]  keys;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [20:0] ex(input logic [4:0] f, input int m2, input int m1, input int cnt);
    return {f, 4'(m2), 4'(m1), 4'(cnt / 10), 4'(cnt % 10)};
  endfunction

  function automatic logic [20:0] obs();
    return {EN, SET, EN_work, EN_set, full, max2, max1, ten, one};
  endfunction

  function automatic void add(input logic [5:0] k, input logic [20:0] e);
    vec_t v;
    v.keys = k;
    v.exp  = e;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [20:0] e);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, obs(), e);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic e);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", nm, got, e);
    end
  endtask

  task automatic drive(input logic [5:0] k);
    {start_key, stop_key, set_key, sel_key, inc_key, bottle} = k;
    @(posedge CLK);
    #1;
    {start_key, stop_key, set_key, sel_key, inc_key, bottle} = K_NONE;
  endtask

  task automatic step(input string nm, input logic [5:0] k, input logic [20:0] e);
    drive(k);
    check(nm, e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    // Fill to target 12, then stop clears the full count.
    add(K_START, ex(F_WORK, 1, 2, 0));
    for (int i = 1; i <= 11; i++) add(K_BOT, ex(F_WORK, 1, 2, i));
    add(K_BOT,  ex(F_FULL, 1, 2, 12));
    add(K_STOP, ex(F_IDLE, 1, 2, 0));
    // Edit target to 15; ten increments wrap max2 through 0 back to 1.
    add(K_SET, ex(F_SETUP, 1, 2, 0));
    for (int i = 1; i <= 3; i++) add(K_INC, ex(F_SETUP, 1, 2 + i, 0));
    add(K_SEL, ex(F_SETUP, 1, 5, 0));
    for (int i = 1; i <= 10; i++) add(K_INC, ex(F_SETUP, (1 + i) % 10, 5, 0));
    add(K_SET, ex(F_IDLE, 1, 5, 0));
    // Setup ignores run keys; sel+inc together bumps max1 then toggles.
    add(K_SET,         ex(F_SETUP, 1, 5, 0));
    add(K_START,       ex(F_SETUP, 1, 5, 0));
    add(K_BOT,         ex(F_SETUP, 1, 5, 0));
    add(K_STOP,        ex(F_SETUP, 1, 5, 0));
    add(K_SEL | K_INC, ex(F_SETUP, 1, 6, 0));
    add(K_INC,         ex(F_SETUP, 2, 6, 0));
    add(K_SEL,         ex(F_SETUP, 2, 6, 0));
    add(K_INC,         ex(F_SETUP, 2, 7, 0));
    add(K_SET,         ex(F_IDLE, 2, 7, 0));
    // Stop with a same-cycle bottle at count 05, then resume.
    add(K_START, ex(F_WORK, 2, 7, 0));
    for (int i = 1; i <= 5; i++) add(K_BOT, ex(F_WORK, 2, 7, i));
    add(K_STOP | K_BOT, ex(F_IDLE, 2, 7, 6));
    add(K_START,        ex(F_WORK, 2, 7, 6));

    #12;
    check("reset_state", ex(F_IDLE, 1, 2, 0));
    check_bit("reset_print1", print1, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].keys);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Page flips every 4 cycles after WORK entry; stop forces it low.
    for (int k = 1; k <= 13; k++) begin
      drive(K_NONE);
      check($sformatf("page_state%0d", k), ex(F_WORK, 2, 7, 6));
      check_bit($sformatf("print1_k%0d", k), print1, ((k / 4) % 2) == 1);
    end
    step("page_stop", K_STOP, ex(F_IDLE, 2, 7, 6));
    check_bit("print1_after_stop", print1, 1'b0);

    // Reaching target beats a simultaneous stop; FULL ignores bottles.
    step("fp_start", K_START, ex(F_WORK, 2, 7, 6));
    for (int c = 7; c <= 26; c++) step($sformatf("fp_cnt%0d", c), K_BOT, ex(F_WORK, 2, 7, c));
    step("fp_bot_stop",   K_BOT | K_STOP,   ex(F_FULL, 2, 7, 27));
    step("fp_full_bot",   K_BOT,            ex(F_FULL, 2, 7, 27));
    step("fp_start_stop", K_START | K_STOP, ex(F_WORK, 2, 7, 0));
    step("fp_stop",       K_STOP,           ex(F_IDLE, 2, 7, 0));

    // Target 00 refuses to start.
    do_reset();
    check("rst2_state", ex(F_IDLE, 1, 2, 0));
    step("z_set", K_SET, ex(F_SETUP, 1, 2, 0));
    for (int i = 1; i <= 8; i++) step($sformatf("z_l%0d", i), K_INC, ex(F_SETUP, 1, (2 + i) % 10, 0));
    step("z_sel", K_SEL, ex(F_SETUP, 1, 0, 0));
    for (int i = 1; i <= 9; i++) step($sformatf("z_h%0d", i), K_INC, ex(F_SETUP, (1 + i) % 10, 0, 0));
    step("z_leave", K_SET,   ex(F_IDLE, 0, 0, 0));
    step("z_start", K_START, ex(F_IDLE, 0, 0, 0));

    // Asynchronous reset mid-WORK at count 07.
    do_reset();
    step("ar_start", K_START, ex(F_WORK, 1, 2, 0));
    for (int i = 1; i <= 7; i++) step($sformatf("ar_cnt%0d", i), K_BOT, ex(F_WORK, 1, 2, i));
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_async", ex(F_IDLE, 1, 2, 0));
    check_bit("ar_print1", print1, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    step("ar_restart", K_START, ex(F_WORK, 1, 2, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
